// File: rtl/axis_demux_1to8_if.sv
// Bus bundle for the 1-to-8 AXI-Stream style demultiplexer.
// Upstream: sel, s_data, s_valid, s_last -> s_ready.
// Downstream per channel i (0..7): data_i, valid_i, last_i <- ready_i.
// Status: busy (a packet is open and its destination is locked).
// master = upstream source / downstream sinks side, slave = demux side.
interface axis_demux_1to8_if #(
    parameter int unsigned WIDTH = 16
);
    logic [2:0]       sel;
    logic [WIDTH-1:0] s_data;
    logic             s_valid;
    logic             s_last;
    logic             s_ready;

    logic [WIDTH-1:0] data_0, data_1, data_2, data_3;
    logic [WIDTH-1:0] data_4, data_5, data_6, data_7;
    logic             valid_0, valid_1, valid_2, valid_3;
    logic             valid_4, valid_5, valid_6, valid_7;
    logic             last_0, last_1, last_2, last_3;
    logic             last_4, last_5, last_6, last_7;
    logic             ready_0, ready_1, ready_2, ready_3;
    logic             ready_4, ready_5, ready_6, ready_7;

    logic             busy;

    modport master (
        output sel, s_data, s_valid, s_last,
        output ready_0, ready_1, ready_2, ready_3, ready_4, ready_5, ready_6, ready_7,
        input  s_ready, busy,
        input  data_0, data_1, data_2, data_3, data_4, data_5, data_6, data_7,
        input  valid_0, valid_1, valid_2, valid_3, valid_4, valid_5, valid_6, valid_7,
        input  last_0, last_1, last_2, last_3, last_4, last_5, last_6, last_7
    );

    modport slave (
        input  sel, s_data, s_valid, s_last,
        input  ready_0, ready_1, ready_2, ready_3, ready_4, ready_5, ready_6, ready_7,
        output s_ready, busy,
        output data_0, data_1, data_2, data_3, data_4, data_5, data_6, data_7,
        output valid_0, valid_1, valid_2, valid_3, valid_4, valid_5, valid_6, valid_7,
        output last_0, last_1, last_2, last_3, last_4, last_5, last_6, last_7
    );
endinterface

// File: rtl/axis_demux_1to8.sv
// 1-to-8 stream demultiplexer with per-packet destination lock.
// The destination is taken from sel on the first beat of a packet and held
// until the beat carrying s_last. A single output register slice carries the
// beat to its channel one cycle after acceptance; s_ready depends only on the
// slice's own destination, so full throughput is sustained.
// Ports: clk, rst_n (async, active-low), bus (slave modport of
// axis_demux_1to8_if: upstream sel/s_data/s_valid/s_last/s_ready, eight
// downstream data_i/valid_i/last_i/ready_i channels, busy).
module axis_demux_1to8 #(
    parameter int unsigned WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    axis_demux_1to8_if.slave      bus
);
    typedef enum logic {
        IDLE = 1'b0,
        PKT  = 1'b1
    } state_t;

    state_t           state;
    logic [2:0]       dest_lock;
    logic             out_vld;
    logic [2:0]       out_dest;
    logic [WIDTH-1:0] out_data;
    logic             out_last;

    logic [7:0]       ready_vec;
    logic [7:0]       vld_vec;
    logic [2:0]       beat_dest;
    logic             s_ready_int;
    logic             accept;
    logic             drain;

    // Gather per-channel readies so the slice destination can index them.
    always_comb begin
        ready_vec = {bus.ready_7, bus.ready_6, bus.ready_5, bus.ready_4,
                     bus.ready_3, bus.ready_2, bus.ready_1, bus.ready_0};
    end

    // Only the channel currently holding the slice can stall upstream.
    assign s_ready_int = !out_vld || ready_vec[out_dest];
    assign accept      = bus.s_valid && s_ready_int;
    assign drain       = out_vld && ready_vec[out_dest];
    assign beat_dest   = (state == IDLE) ? bus.sel : dest_lock;

    // Packet FSM, destination lock and output slice.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            dest_lock <= 3'd0;
            out_vld   <= 1'b0;
            out_dest  <= 3'd0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        dest_lock <= bus.sel;
                        if (!bus.s_last) begin
                            state <= PKT;
                        end
                    end
                end
                PKT: begin
                    if (accept && bus.s_last) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // Accept wins over drain so a simultaneous drain+accept refills the slice.
            if (accept) begin
                out_vld  <= 1'b1;
                out_dest <= beat_dest;
                out_data <= bus.s_data;
                out_last <= bus.s_last;
            end else if (drain) begin
                out_vld <= 1'b0;
            end
        end
    end

    always_comb begin
        vld_vec = '0;
        for (int i = 0; i < 8; i++) begin
            vld_vec[i] = out_vld && (out_dest == 3'(i));
        end
    end

    assign bus.s_ready = s_ready_int;
    assign bus.busy    = (state == PKT);

    assign bus.valid_0 = vld_vec[0];
    assign bus.valid_1 = vld_vec[1];
    assign bus.valid_2 = vld_vec[2];
    assign bus.valid_3 = vld_vec[3];
    assign bus.valid_4 = vld_vec[4];
    assign bus.valid_5 = vld_vec[5];
    assign bus.valid_6 = vld_vec[6];
    assign bus.valid_7 = vld_vec[7];

    // Non-selected channels see zero payload.
    assign bus.data_0 = (out_dest == 3'd0) ? out_data : '0;
    assign bus.data_1 = (out_dest == 3'd1) ? out_data : '0;
    assign bus.data_2 = (out_dest == 3'd2) ? out_data : '0;
    assign bus.data_3 = (out_dest == 3'd3) ? out_data : '0;
    assign bus.data_4 = (out_dest == 3'd4) ? out_data : '0;
    assign bus.data_5 = (out_dest == 3'd5) ? out_data : '0;
    assign bus.data_6 = (out_dest == 3'd6) ? out_data : '0;
    assign bus.data_7 = (out_dest == 3'd7) ? out_data : '0;

    assign bus.last_0 = (out_dest == 3'd0) && out_last;
    assign bus.last_1 = (out_dest == 3'd1) && out_last;
    assign bus.last_2 = (out_dest == 3'd2) && out_last;
    assign bus.last_3 = (out_dest == 3'd3) && out_last;
    assign bus.last_4 = (out_dest == 3'd4) && out_last;
    assign bus.last_5 = (out_dest == 3'd5) && out_last;
    assign bus.last_6 = (out_dest == 3'd6) && out_last;
    assign bus.last_7 = (out_dest == 3'd7) && out_last;
endmodule

// File: tb/tb_axis_demux_1to8.sv
// Self-checking bench for axis_demux_1to8: directed scenarios followed by
// randomized traffic, all compared every cycle against a packet-level model
// (pending-beat queue, open-packet flag, locked destination).
module tb_axis_demux_1to8;
    localparam int unsigned WIDTH = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    axis_demux_1to8_if #(.WIDTH(WIDTH)) bus ();

    axis_demux_1to8 #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [7:0] rdy;
    assign bus.ready_0 = rdy[0];
    assign bus.ready_1 = rdy[1];
    assign bus.ready_2 = rdy[2];
    assign bus.ready_3 = rdy[3];
    assign bus.ready_4 = rdy[4];
    assign bus.ready_5 = rdy[5];
    assign bus.ready_6 = rdy[6];
    assign bus.ready_7 = rdy[7];

    logic [7:0][WIDTH-1:0] d_arr;
    logic [7:0]            v_arr;
    logic [7:0]            l_arr;
    assign d_arr = {bus.data_7, bus.data_6, bus.data_5, bus.data_4,
                    bus.data_3, bus.data_2, bus.data_1, bus.data_0};
    assign v_arr = {bus.valid_7, bus.valid_6, bus.valid_5, bus.valid_4,
                    bus.valid_3, bus.valid_2, bus.valid_1, bus.valid_0};
    assign l_arr = {bus.last_7, bus.last_6, bus.last_5, bus.last_4,
                    bus.last_3, bus.last_2, bus.last_1, bus.last_0};

    typedef struct packed {
        logic [2:0]       dest;
        logic [WIDTH-1:0] data;
        logic             last;
    } beat_t;

    // Model: beats accepted but not yet delivered, most recent accepted beat,
    // and the packet state (open flag + locked destination).
    beat_t      pend_q[$];
    beat_t      last_beat;
    bit         m_open;
    logic [2:0] m_lock;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit exp_ready();
        return (pend_q.size() == 0) || rdy[pend_q[0].dest];
    endfunction

    task automatic model_reset();
        pend_q.delete();
        last_beat = '0;
        m_open    = 1'b0;
        m_lock    = 3'd0;
    endtask

    task automatic check_outputs();
        bit ev;
        chk("s_ready", 32'(bus.s_ready), 32'(exp_ready()));
        chk("busy", 32'(bus.busy), 32'(m_open));
        for (int i = 0; i < 8; i++) begin
            ev = (pend_q.size() != 0) && (pend_q[0].dest == 3'(i));
            chk($sformatf("valid_%0d", i), 32'(v_arr[i]), 32'(ev));
            chk($sformatf("data_%0d", i), 32'(d_arr[i]),
                (last_beat.dest == 3'(i)) ? 32'(last_beat.data) : 32'd0);
            chk($sformatf("last_%0d", i), 32'(l_arr[i]),
                32'((last_beat.dest == 3'(i)) && last_beat.last));
        end
    endtask

    // One clock cycle: drive, check, clock, advance model. Entered and left at posedge+1.
    task automatic cycle(input logic sv, input logic [2:0] s, input logic [WIDTH-1:0] d,
                         input logic l, input logic [7:0] r);
        bit         acc;
        bit         drn;
        logic [2:0] dst;
        bus.s_valid = sv;
        bus.sel     = s;
        bus.s_data  = d;
        bus.s_last  = l;
        rdy         = r;
        #1;
        check_outputs();
        acc = sv && exp_ready();
        drn = (pend_q.size() != 0) && r[pend_q[0].dest];
        dst = m_open ? m_lock : s;
        @(posedge clk);
        if (drn) void'(pend_q.pop_front());
        if (acc) begin
            last_beat = '{dest: dst, data: d, last: l};
            pend_q.push_back(last_beat);
            if (!m_open) begin
                m_lock = s;
                m_open = !l;
            end else if (l) begin
                m_open = 1'b0;
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, 3'd0, '0, 1'b0, 8'hFF);
    endtask

    logic [WIDTH-1:0] held;

    initial begin
        rst_n       = 1'b0;
        bus.s_valid = 1'b0;
        bus.sel     = 3'd0;
        bus.s_data  = '0;
        bus.s_last  = 1'b0;
        rdy         = 8'hFF;
        model_reset();
        @(posedge clk);
        #1;
        check_outputs();
        chk("rst_s_ready", 32'(bus.s_ready), 32'd1);
        chk("rst_valid", 32'(v_arr), 32'd0);
        rst_n = 1'b1;
        idle(1);

        // Single-beat packet to channel 5.
        cycle(1'b1, 3'd5, 16'hA5A5, 1'b1, 8'hFF);
        chk("single_valid", 32'(v_arr), 32'h20);
        chk("single_data5", 32'(d_arr[5]), 32'hA5A5);
        chk("single_last5", 32'(l_arr[5]), 32'd1);
        chk("single_busy", 32'(bus.busy), 32'd0);
        idle(1);

        // Four-beat packet locked to channel 2 despite sel moving to 6.
        cycle(1'b1, 3'd2, 16'h2001, 1'b0, 8'hFF);
        chk("lock_busy1", 32'(bus.busy), 32'd1);
        chk("lock_v1", 32'(v_arr), 32'h04);
        cycle(1'b1, 3'd6, 16'h2002, 1'b0, 8'hFF);
        chk("lock_v2", 32'(v_arr), 32'h04);
        chk("lock_last_b2", 32'(l_arr[2]), 32'd0);
        cycle(1'b1, 3'd6, 16'h2003, 1'b0, 8'hFF);
        chk("lock_busy3", 32'(bus.busy), 32'd1);
        cycle(1'b1, 3'd6, 16'h2004, 1'b1, 8'hFF);
        chk("lock_v4", 32'(v_arr), 32'h04);
        chk("lock_data4", 32'(d_arr[2]), 32'h2004);
        chk("lock_last4", 32'(l_arr[2]), 32'd1);
        chk("lock_busy4", 32'(bus.busy), 32'd0);
        idle(1);

        // Back-pressure on channel 3, then drain and accept in the same cycle.
        cycle(1'b1, 3'd3, 16'hBEEF, 1'b1, 8'hF7);
        held = d_arr[3];
        chk("bp_first", 32'(held), 32'hBEEF);
        for (int k = 0; k < 5; k++) begin
            cycle(1'b1, 3'd0, 16'h1111, 1'b1, 8'hF7);
            chk("bp_s_ready", 32'(bus.s_ready), 32'd0);
            chk("bp_hold3", 32'(d_arr[3]), 32'(held));
            chk("bp_valid3", 32'(v_arr), 32'h08);
        end
        cycle(1'b1, 3'd0, 16'h1111, 1'b1, 8'hFF);
        chk("bp_refill_v", 32'(v_arr), 32'h01);
        chk("bp_refill_d", 32'(d_arr[0]), 32'h1111);
        idle(1);

        // Sustained streaming on channel 1.
        for (int k = 0; k < 16; k++) begin
            cycle(1'b1, 3'd1, WIDTH'(16'h1100 + k), 1'(k == 15), 8'hFF);
            chk("stream_ready", 32'(bus.s_ready), 32'd1);
            chk("stream_data", 32'(d_arr[1]), 32'(16'h1100 + k));
        end
        idle(1);

        // Back-to-back packets: channel 0 then channel 7 with no gap.
        cycle(1'b1, 3'd0, 16'h0A01, 1'b0, 8'hFF);
        cycle(1'b1, 3'd3, 16'h0A02, 1'b1, 8'hFF);
        chk("b2b_v0", 32'(v_arr), 32'h01);
        cycle(1'b1, 3'd7, 16'h0B01, 1'b1, 8'hFF);
        chk("b2b_v7", 32'(v_arr), 32'h80);
        chk("b2b_d7", 32'(d_arr[7]), 32'h0B01);
        idle(1);

        // Reset during a packet to channel 4.
        cycle(1'b1, 3'd4, 16'h4001, 1'b0, 8'hFF);
        cycle(1'b1, 3'd4, 16'h4002, 1'b0, 8'hFF);
        bus.s_valid = 1'b0;
        rst_n       = 1'b0;
        model_reset();
        #1;
        check_outputs();
        chk("mid_rst_valid", 32'(v_arr), 32'd0);
        chk("mid_rst_data4", 32'(d_arr[4]), 32'd0);
        chk("mid_rst_ready", 32'(bus.s_ready), 32'd1);
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle(1'b1, 3'd1, 16'h1001, 1'b1, 8'hFF);
        chk("post_rst_v1", 32'(v_arr), 32'h02);
        chk("post_rst_d1", 32'(d_arr[1]), 32'h1001);
        idle(1);

        // Randomized traffic with random back-pressure.
        for (int k = 0; k < 400; k++) begin
            cycle(1'($urandom_range(0, 3) != 0), 3'($urandom), WIDTH'($urandom),
                  1'($urandom_range(0, 3) == 0), 8'($urandom | $urandom));
        end
        idle(3);
        chk("final_empty", 32'(v_arr), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/axis_demux_1to8.md
AXIS_DEMUX_1TO8 -- requirements
Module: axis_demux_1to8

Interface
REQ-001 Parameter: WIDTH, default 16, payload width in bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 sel  input  3  destination select; sampled only on the first beat of a packet.
REQ-005 s_data  input  WIDTH  upstream payload.
REQ-006 s_valid  input  1  upstream beat valid.
REQ-007 s_last  input  1  upstream end-of-packet marker.
REQ-008 s_ready  output  1  upstream ready.
REQ-009 data_0..data_7  output  WIDTH each  per-destination payload.
REQ-010 valid_0..valid_7  output  1 each  per-destination valid.
REQ-011 last_0..last_7  output  1 each  per-destination end-of-packet marker.
REQ-012 ready_0..ready_7  input  1 each  per-destination ready.
REQ-013 busy  output  1  high while a packet is in progress (state PKT).

Function
REQ-014 Accepted beat: s_valid && s_ready high on a rising clk edge.
REQ-015 The FSM SHALL have two states: IDLE (no open packet) and PKT (packet open, destination locked).
REQ-016 Beat destination SHALL be sel in IDLE and the locked register dest_lock in PKT.
REQ-017 In IDLE, an accepted beat SHALL load dest_lock <= sel; if s_last=0, next state is PKT; if s_last=1, the state stays IDLE (single-beat packet).
REQ-018 In PKT, an accepted beat with s_last=1 SHALL return the FSM to IDLE; sel changes in PKT SHALL have no effect.
REQ-019 Output stage: one register slice {out_vld, out_dest[2:0], out_data, out_last}, loaded with the beat and its destination on every accepted beat.
REQ-020 s_ready SHALL equal !out_vld || ready_<out_dest> (combinational; full throughput, one beat per cycle sustained).
REQ-021 out_vld SHALL set on an accepted beat, and clear when the slice drains (out_vld && ready_<out_dest>) with no beat accepted in the same cycle; simultaneous drain and accept SHALL keep out_vld=1 with the new contents.
REQ-022 valid_i = out_vld && (out_dest==i); data_i and last_i SHALL equal out_data/out_last when out_dest==i, else zero.
REQ-023 Latency: an accepted beat SHALL appear on its destination outputs in the next cycle.
REQ-024 A back-pressured destination SHALL stall only via s_ready; ready_j for j!=out_dest SHALL be ignored.
REQ-025 No beat SHALL be dropped, duplicated or reordered; an out_data value is held stable while valid_i=1 and ready_i=0.
REQ-026 busy SHALL equal (state==PKT).

Reset
REQ-027 While rst_n=0: state=IDLE, dest_lock=0, out_vld=0, out_dest=0, out_data=0, out_last=0; hence all valid_i=0, data_i=0, last_i=0, busy=0, s_ready=1.
REQ-028 Reset assertion mid-packet SHALL discard the held beat and open packet; after release the next accepted beat is treated as a first beat (sel sampled).

Verification
REQ-029 Single beat: sel=5, s_data=16'hA5A5, s_last=1, ready_5=1 -> next cycle valid_5=1, data_5=16'hA5A5, last_5=1, all other valid_i=0, busy=0.
REQ-030 Packet lock: sel=2, 4-beat packet, sel changed to 6 after beat 1 -> all 4 beats on channel 2, last_2=1 on beat 4 only, busy=1 from beat 1 until the beat-4 accept, then 0.
REQ-031 Back-pressure: ready_3=0 with a beat held on channel 3 -> s_ready=0, data_3 stable for 5 cycles; ready_3=1 -> drain, then a new beat accepted in the same cycle, no gap.
REQ-032 Streaming: ready_1=1, s_valid=1 continuously, 16 beats on sel=1 -> s_ready=1 every cycle, 16 beats out in order, one per cycle.
REQ-033 Back-to-back packets: packet to 0 ending with s_last=1 followed immediately by a beat with sel=7 -> second packet routed to channel 7 with no idle cycle.
REQ-034 Reset mid-packet: rst_n=0 during beat 2 of a packet to channel 4 -> all outputs 0, s_ready=1; after release, sel=1 beat -> appears on channel 1.
